// File: rtl/perf_event_collector_if.sv
// Event-source / counter-block bundle for perf_event_collector.
// master = event sources plus consumer handshake (hold/lost_clr); slave = collector.
// inc_o/lost_o are the only signals the collector drives.
interface perf_event_collector_if #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int CNT_W           = 4
);
  logic                         debug_mode_i;
  logic [15:0]                  inhibit_i;
  logic                         l1_icache_miss_i;
  logic                         l1_dcache_miss_i;
  logic                         itlb_miss_i;
  logic                         dtlb_miss_i;
  logic                         sb_full_i;
  logic                         if_empty_i;
  logic                         ex_valid_i;
  logic                         eret_i;
  logic                         mispredict_i;
  logic [NR_COMMIT_PORTS-1:0]   commit_ack_i;
  logic [3*NR_COMMIT_PORTS-1:0] commit_class_i;
  logic                         hold_i;
  logic                         lost_clr_i;
  logic [16*CNT_W-1:0]          inc_o;
  logic                         lost_o;

  modport master (
    output debug_mode_i, inhibit_i,
    output l1_icache_miss_i, l1_dcache_miss_i, itlb_miss_i, dtlb_miss_i,
    output sb_full_i, if_empty_i, ex_valid_i, eret_i, mispredict_i,
    output commit_ack_i, commit_class_i,
    output hold_i, lost_clr_i,
    input  inc_o, lost_o
  );

  modport slave (
    input  debug_mode_i, inhibit_i,
    input  l1_icache_miss_i, l1_dcache_miss_i, itlb_miss_i, dtlb_miss_i,
    input  sb_full_i, if_empty_i, ex_valid_i, eret_i, mispredict_i,
    input  commit_ack_i, commit_class_i,
    input  hold_i, lost_clr_i,
    output inc_o, lost_o
  );
endinterface

// File: rtl/perf_event_collector.sv
// Reduces event strobes and commit info to 16 gated per-event increment counts.
// Latency: one cycle, inputs sampled at edge N are on inc_o after edge N.
// Backpressure: while hold_i is high, increments accumulate with saturation; lost_o flags overflow.
module perf_event_collector #(
  parameter int NR_COMMIT_PORTS = 2,
  parameter int CNT_W           = 4
) (
  input logic                  clk_i,
  input logic                  rst_i,
  perf_event_collector_if.slave bus
);

  logic [CNT_W-1:0]    cur   [16];
  logic [CNT_W-1:0]    g     [16];
  logic [CNT_W:0]      sum   [16];
  logic [CNT_W-1:0]    inc_q [16];
  logic                lost_q;
  logic                any_ovf;
  logic [16*CNT_W-1:0] inc_flat;

  // Raw per-event counts for this cycle; commit ports only count when acknowledged.
  always_comb begin
    for (int k = 0; k < 16; k++) cur[k] = '0;
    cur[0]  = CNT_W'(bus.l1_icache_miss_i);
    cur[1]  = CNT_W'(bus.l1_dcache_miss_i);
    cur[2]  = CNT_W'(bus.itlb_miss_i);
    cur[3]  = CNT_W'(bus.dtlb_miss_i);
    cur[6]  = CNT_W'(bus.ex_valid_i);
    cur[7]  = CNT_W'(bus.eret_i);
    cur[11] = CNT_W'(bus.mispredict_i);
    cur[12] = CNT_W'(bus.sb_full_i);
    cur[13] = CNT_W'(bus.if_empty_i);
    cur[14] = CNT_W'(1);
    for (int p = 0; p < NR_COMMIT_PORTS; p++) begin
      if (bus.commit_ack_i[p]) begin
        cur[15] = cur[15] + CNT_W'(1);
        case (bus.commit_class_i[3*p +: 3])
          3'd1:    cur[4]  = cur[4]  + CNT_W'(1);
          3'd2:    cur[5]  = cur[5]  + CNT_W'(1);
          3'd3:    cur[8]  = cur[8]  + CNT_W'(1);
          3'd4:    cur[9]  = cur[9]  + CNT_W'(1);
          3'd5:    cur[10] = cur[10] + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Debug/inhibit gating and the one-bit-wider accumulate sum used for saturation.
  always_comb begin
    any_ovf = 1'b0;
    for (int k = 0; k < 16; k++) begin
      g[k]    = (bus.debug_mode_i | bus.inhibit_i[k]) ? '0 : cur[k];
      sum[k]  = {1'b0, inc_q[k]} + {1'b0, g[k]};
      any_ovf = any_ovf | sum[k][CNT_W];
    end
  end

  // Increment registers: reload on consume, saturating accumulate while held; sticky loss flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < 16; k++) inc_q[k] <= '0;
      lost_q <= 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (bus.hold_i) inc_q[k] <= sum[k][CNT_W] ? '1 : sum[k][CNT_W-1:0];
        else            inc_q[k] <= g[k];
      end
      if (bus.hold_i && any_ovf) lost_q <= 1'b1;
      else if (bus.lost_clr_i)   lost_q <= 1'b0;
    end
  end

  // Flatten the per-event registers onto the output bus, event k at [k*CNT_W +: CNT_W].
  always_comb begin
    inc_flat = '0;
    for (int k = 0; k < 16; k++) inc_flat[k*CNT_W +: CNT_W] = inc_q[k];
  end

  assign bus.inc_o  = inc_flat;
  assign bus.lost_o = lost_q;

endmodule

// File: tb/tb_perf_event_collector.sv
// Scoreboard bench for perf_event_collector: a behavioural model pushes the expected
// inc_o/lost_o for each driven cycle; the entry is popped and compared after the edge.
module tb_perf_event_collector;
  localparam int NP = 2;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  perf_event_collector_if #(.NR_COMMIT_PORTS(NP), .CNT_W(CW)) bus ();

  perf_event_collector #(.NR_COMMIT_PORTS(NP), .CNT_W(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [64:0] exp_q [$];
  int          m_inc [16];
  logic        m_lost = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] fld(input int k);
    logic [63:0] v;
    v = bus.inc_o;
    return {60'd0, v[k*CW +: CW]};
  endfunction

  task automatic set_strobes(input logic v);
    bus.l1_icache_miss_i = v; bus.l1_dcache_miss_i = v;
    bus.itlb_miss_i      = v; bus.dtlb_miss_i      = v;
    bus.sb_full_i        = v; bus.if_empty_i       = v;
    bus.ex_valid_i       = v; bus.eret_i           = v;
    bus.mispredict_i     = v;
  endtask

  // Expected gated count for event k from the current stimulus.
  function automatic int model_g(input int k);
    int n_ld, n_st, n_br, n_cl, n_rt, n_ack, v;
    n_ld = 0; n_st = 0; n_br = 0; n_cl = 0; n_rt = 0; n_ack = 0;
    for (int p = 0; p < NP; p++) begin
      if (bus.commit_ack_i[p]) begin
        n_ack++;
        if (bus.commit_class_i[3*p +: 3] == 3'd1) n_ld++;
        if (bus.commit_class_i[3*p +: 3] == 3'd2) n_st++;
        if (bus.commit_class_i[3*p +: 3] == 3'd3) n_br++;
        if (bus.commit_class_i[3*p +: 3] == 3'd4) n_cl++;
        if (bus.commit_class_i[3*p +: 3] == 3'd5) n_rt++;
      end
    end
    case (k)
      0: v = int'(bus.l1_icache_miss_i);   1: v = int'(bus.l1_dcache_miss_i);
      2: v = int'(bus.itlb_miss_i);        3: v = int'(bus.dtlb_miss_i);
      4: v = n_ld;                         5: v = n_st;
      6: v = int'(bus.ex_valid_i);         7: v = int'(bus.eret_i);
      8: v = n_br;                         9: v = n_cl;
      10: v = n_rt;                        11: v = int'(bus.mispredict_i);
      12: v = int'(bus.sb_full_i);         13: v = int'(bus.if_empty_i);
      14: v = 1;
      default: v = n_ack;
    endcase
    if (bus.debug_mode_i || bus.inhibit_i[k]) v = 0;
    return v;
  endfunction

  // Advance the model for the stimulus now applied, push its prediction, clock, compare.
  task automatic step(input string tag);
    logic [64:0] e;
    logic [64:0] o;
    int g [16];
    bit ovf;
    ovf = 1'b0;
    for (int k = 0; k < 16; k++) g[k] = model_g(k);
    if (rst) begin
      for (int k = 0; k < 16; k++) m_inc[k] = 0;
      m_lost = 1'b0;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (bus.hold_i) begin
          if (m_inc[k] + g[k] > 15) begin ovf = 1'b1; m_inc[k] = 15; end
          else m_inc[k] = m_inc[k] + g[k];
        end else begin
          m_inc[k] = g[k];
        end
      end
      if (bus.hold_i && ovf) m_lost = 1'b1;
      else if (bus.lost_clr_i) m_lost = 1'b0;
    end
    e = '0;
    for (int k = 0; k < 16; k++) e[k*CW +: CW] = m_inc[k][CW-1:0];
    e[64] = m_lost;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_queue got=empty expected=entry", tag);
    end else begin
      o = exp_q.pop_front();
      check({tag, "_inc"},  bus.inc_o, o[63:0]);
      check({tag, "_lost"}, {63'd0, bus.lost_o}, {63'd0, o[64]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.debug_mode_i = 1'b0; bus.inhibit_i = 16'h0;
    bus.commit_ack_i = '1;   bus.commit_class_i = 6'o21;
    bus.hold_i = 1'b0;       bus.lost_clr_i = 1'b0;
    set_strobes(1'b1);
    @(posedge clk); #1;

    // Reset with everything active
    rst = 1'b1;
    step("rst0");
    step("rst1");
    check("rst_inc_zero", bus.inc_o, 64'd0);
    check("rst_lost_zero", {63'd0, bus.lost_o}, 64'd0);
    rst = 1'b0;
    set_strobes(1'b0); bus.commit_ack_i = '0;
    step("post_rst");
    check("post_rst_cycles", fld(14), 64'd1);

    // Commit mix: port0 load, port1 store
    bus.commit_ack_i = 2'b11; bus.commit_class_i = {3'd2, 3'd1};
    step("mix_ls");
    check("mix_ls_vec", bus.inc_o, 64'h2100_0000_0011_0000);
    check("mix_ls_instret", fld(15), 64'd2);
    // port0 call acked, port1 load not acked
    bus.commit_ack_i = 2'b01; bus.commit_class_i = {3'd1, 3'd4};
    step("mix_cl");
    check("mix_cl_load", fld(4), 64'd0);
    check("mix_cl_call", fld(9), 64'd1);
    check("mix_cl_instret", fld(15), 64'd1);

    // Hold accumulation with an icache miss every cycle
    bus.commit_ack_i = '0; bus.l1_icache_miss_i = 1'b1;
    step("acc_load");
    check("acc_1", fld(0), 64'd1);
    bus.hold_i = 1'b1;
    step("acc_h1");
    check("acc_2", fld(0), 64'd2);
    step("acc_h2");
    check("acc_3", fld(0), 64'd3);
    bus.hold_i = 1'b0;
    step("acc_rel");
    check("acc_rel_fresh", fld(0), 64'd1);
    check("acc_no_loss", {63'd0, bus.lost_o}, 64'd0);

    // Saturation of the cycle counter under a long hold
    bus.l1_icache_miss_i = 1'b0;
    bus.hold_i = 1'b1;
    for (int i = 0; i < 20; i++) step("sat");
    check("sat_cycles", fld(14), 64'd15);
    check("sat_lost", {63'd0, bus.lost_o}, 64'd1);
    bus.hold_i = 1'b0; bus.lost_clr_i = 1'b1;
    step("sat_clr");
    check("sat_lost_cleared", {63'd0, bus.lost_o}, 64'd0);
    bus.lost_clr_i = 1'b0;

    // Gating: debug mode, then per-event inhibit
    set_strobes(1'b1); bus.commit_ack_i = '1; bus.debug_mode_i = 1'b1;
    step("dbg");
    check("dbg_zero", bus.inc_o, 64'd0);
    bus.debug_mode_i = 1'b0; bus.inhibit_i = 16'h8001;
    step("inh");
    check("inh_icache", fld(0), 64'd0);
    check("inh_instret", fld(15), 64'd0);
    check("inh_dcache", fld(1), 64'd1);
    check("inh_cycles", fld(14), 64'd1);
    bus.inhibit_i = 16'h0;

    // Reset in the middle of a hold
    set_strobes(1'b0); bus.commit_ack_i = '0;
    step("mid_load");
    bus.hold_i = 1'b1;
    for (int i = 0; i < 4; i++) step("mid_hold");
    check("mid_cycles5", fld(14), 64'd5);
    rst = 1'b1;
    step("mid_rst");
    check("mid_rst_zero", bus.inc_o, 64'd0);
    rst = 1'b0; bus.hold_i = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      bus.l1_icache_miss_i = 1'($urandom); bus.l1_dcache_miss_i = 1'($urandom);
      bus.itlb_miss_i      = 1'($urandom); bus.dtlb_miss_i      = 1'($urandom);
      bus.sb_full_i        = 1'($urandom); bus.if_empty_i       = 1'($urandom);
      bus.ex_valid_i       = 1'($urandom); bus.eret_i           = 1'($urandom);
      bus.mispredict_i     = 1'($urandom);
      bus.commit_ack_i     = 2'($urandom);
      bus.commit_class_i   = 6'($urandom);
      bus.debug_mode_i     = ($urandom_range(0, 15) == 0);
      bus.inhibit_i        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      bus.hold_i           = ($urandom_range(0, 3) != 0);
      bus.lost_clr_i       = ($urandom_range(0, 7) == 0);
      rst                  = ($urandom_range(0, 63) == 0);
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
